// File: rtl/game_sequencer.sv
// Frame-paced game sequencer. It turns vsync edges into snake tick requests at the
// selected speed, waits for each tick to finish, and tracks the pause, restart and game-over flow.
module game_sequencer #(
  parameter int SPEED_W      = 3,
  parameter int SPEED_INIT   = 2,
  parameter int DONE_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_vsync,
  input  logic               i_pause,
  input  logic               i_restart,
  input  logic               i_start,
  input  logic               i_apple_ready,
  input  logic               i_faster,
  input  logic               i_slower,
  input  logic               i_tick_done,
  input  logic               i_failure,
  input  logic               i_success,
  output logic               o_tick,
  output logic               o_game_rst,
  output logic [2:0]         o_state,
  output logic [SPEED_W-1:0] o_speed,
  output logic               o_failure,
  output logic               o_success,
  output logic               o_dropped
);
  localparam int TO_W = $clog2(DONE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    CLEAR  = 3'd0,
    IDLE   = 3'd1,
    RUN    = 3'd2,
    TICK   = 3'd3,
    BUSY   = 3'd4,
    PAUSED = 3'd5,
    OVER   = 3'd6
  } state_t;

  state_t             state, state_nxt;
  logic               vsync_q;
  logic [SPEED_W-1:0] frame_cnt, frame_nxt;
  logic [TO_W-1:0]    timeout, to_nxt;
  logic               fail_nxt, succ_nxt, drop_nxt;
  logic               vs_edge, elapsed, playing;
  logic [SPEED_W:0]   period, frame_inc;

  // Faster speeds shorten the period; the widest speed value gives one frame per tick.
  assign period    = ((SPEED_W+1)'(1) << SPEED_W) - {1'b0, o_speed};
  assign frame_inc = {1'b0, frame_cnt} + 1'b1;
  assign vs_edge   = i_vsync && !vsync_q;
  assign elapsed   = vs_edge && (frame_inc >= period);
  assign playing   = (state == RUN) || (state == TICK) || (state == BUSY);

  assign o_state    = state;
  assign o_tick     = (state == TICK);
  assign o_game_rst = (state == CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      vsync_q   <= 1'b1;
      frame_cnt <= '0;
      timeout   <= '0;
      o_speed   <= SPEED_W'(SPEED_INIT);
      o_failure <= 1'b0;
      o_success <= 1'b0;
      o_dropped <= 1'b0;
    end else begin
      state     <= state_nxt;
      vsync_q   <= i_vsync;
      frame_cnt <= frame_nxt;
      timeout   <= to_nxt;
      o_failure <= fail_nxt;
      o_success <= succ_nxt;
      o_dropped <= drop_nxt;
      if (i_faster && !i_slower && (o_speed != '1))
        o_speed <= o_speed + 1'b1;
      else if (i_slower && !i_faster && (o_speed != '0))
        o_speed <= o_speed - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    frame_nxt = frame_cnt;
    to_nxt    = timeout;
    fail_nxt  = o_failure;
    succ_nxt  = o_success;
    drop_nxt  = 1'b0;

    // A pause request in RUN freezes the frame count, even on a vsync edge.
    if (playing) begin
      if (vs_edge && !((state == RUN) && i_pause))
        frame_nxt = elapsed ? '0 : frame_cnt + 1'b1;
    end else if ((state == CLEAR) || (state == IDLE)) begin
      frame_nxt = '0;
    end

    case (state)
      CLEAR:  state_nxt = IDLE;
      IDLE:   if (i_start) state_nxt = RUN;
      RUN: begin
        if (i_pause)
          state_nxt = PAUSED;
        else if (elapsed) begin
          if (i_apple_ready) state_nxt = TICK;
          else               drop_nxt  = 1'b1;
        end
      end
      TICK: begin
        state_nxt = BUSY;
        to_nxt    = '0;
        drop_nxt  = elapsed;
      end
      BUSY: begin
        to_nxt   = timeout + 1'b1;
        drop_nxt = elapsed;
        if (i_tick_done)
          state_nxt = RUN;
        else if (to_nxt == TO_W'(DONE_TIMEOUT)) begin
          state_nxt = RUN;
          drop_nxt  = 1'b1;
        end
      end
      PAUSED: if (!i_pause) state_nxt = RUN;
      OVER:   state_nxt = OVER;
      default: state_nxt = CLEAR;
    endcase

    if (playing && (i_failure || i_success)) begin
      state_nxt = OVER;
      drop_nxt  = 1'b0;
      if (i_failure) fail_nxt = 1'b1;
      else           succ_nxt = 1'b1;
    end

    // Restart clears game flags on entry so they already read zero during CLEAR.
    if (i_restart) begin
      state_nxt = CLEAR;
      drop_nxt  = 1'b0;
      frame_nxt = '0;
      fail_nxt  = 1'b0;
      succ_nxt  = 1'b0;
    end
  end
endmodule

// File: tb/tb_game_sequencer.sv
// Directed scenarios plus a randomized phase for game_sequencer, with every cycle
// compared against a behavioural model of the game flow.
module tb_game_sequencer;
  localparam int SW = 3;
  localparam int SI = 2;
  localparam int TO = 255;

  logic clk, rst;
  logic i_vsync, i_pause, i_restart, i_start, i_apple_ready;
  logic i_faster, i_slower, i_tick_done, i_failure, i_success;
  logic o_tick, o_game_rst, o_failure, o_success, o_dropped;
  logic [2:0] o_state;
  logic [SW-1:0] o_speed;

  game_sequencer #(.SPEED_W(SW), .SPEED_INIT(SI), .DONE_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .i_vsync(i_vsync), .i_pause(i_pause), .i_restart(i_restart),
    .i_start(i_start), .i_apple_ready(i_apple_ready), .i_faster(i_faster),
    .i_slower(i_slower), .i_tick_done(i_tick_done), .i_failure(i_failure),
    .i_success(i_success), .o_tick(o_tick), .o_game_rst(o_game_rst), .o_state(o_state),
    .o_speed(o_speed), .o_failure(o_failure), .o_success(o_success), .o_dropped(o_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  // model: game phase (0 clear,1 idle,2 run,3 tick,4 busy,5 paused,6 over)
  int m_st, m_fc, m_busy, m_spd;
  bit m_f, m_s, m_drop, m_vp, m_edge;
  int vcnt = 0, done_cnt = 0, n_tick = 0, n_drop = 0;
  bit auto_done = 0, rand_mode = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_init();
    m_st = 0; m_fc = 0; m_busy = 0; m_spd = SI;
    m_f = 0; m_s = 0; m_drop = 0; m_vp = 1; m_edge = 0; done_cnt = 0;
  endtask

  task automatic model_step();
    int per, nst;
    bit el, drop, play;
    per = (1 << SW) - m_spd;
    m_edge = i_vsync && !m_vp;
    m_vp = i_vsync;
    el = 0; drop = 0; nst = m_st;
    play = (m_st >= 2 && m_st <= 4);
    if (play && m_edge && !(m_st == 2 && i_pause)) begin
      if (m_fc + 1 >= per) begin el = 1; m_fc = 0; end
      else m_fc++;
    end
    if (m_st <= 1) m_fc = 0;
    if (play && (i_failure || i_success)) begin
      nst = 6;
      if (i_failure) m_f = 1; else m_s = 1;
    end else if (m_st == 0) nst = 1;
    else if (m_st == 1) nst = i_start ? 2 : 1;
    else if (m_st == 5) nst = i_pause ? 5 : 2;
    else if (m_st == 2) begin
      if (i_pause) nst = 5;
      else if (el && i_apple_ready) nst = 3;
      else drop = el;
    end else if (m_st == 3) begin
      nst = 4; m_busy = 0; drop = el;
    end else if (m_st == 4) begin
      m_busy++;
      drop = el;
      if (i_tick_done) nst = 2;
      else if (m_busy == TO) begin nst = 2; drop = 1; end
    end
    if (i_restart) begin
      nst = 0; drop = 0; m_fc = 0; m_f = 0; m_s = 0;
    end
    if (i_faster && !i_slower && m_spd < (1 << SW) - 1) m_spd++;
    else if (i_slower && !i_faster && m_spd > 0) m_spd--;
    m_st = nst;
    m_drop = drop;
  endtask

  task automatic cyc();
    if (rand_mode) i_vsync = ($urandom % 3 == 0);
    else i_vsync = (vcnt % 8) < 2;
    vcnt++;
    if (auto_done) begin
      i_tick_done = (done_cnt == 1);
      if (done_cnt > 0) done_cnt--;
    end
    model_step();
    @(posedge clk); #1;
    chk("state", o_state, m_st);
    chk("tick", o_tick, m_st == 3);
    chk("game_rst", o_game_rst, m_st == 0);
    chk("speed", o_speed, m_spd);
    chk("failure", o_failure, m_f);
    chk("success", o_success, m_s);
    chk("dropped", o_dropped, m_drop);
    if (o_tick) n_tick++;
    if (o_dropped) n_drop++;
    if (auto_done && m_st == 3) done_cnt = 3;
    i_faster = 0; i_slower = 0; i_tick_done = 0;
    i_failure = 0; i_success = 0; i_restart = 0;
  endtask

  task automatic run_edges(input int n);
    int e = 0, g = 0;
    while (e < n && g < 200) begin
      cyc();
      if (m_edge) e++;
      g++;
    end
    chk("edges_seen", e, n);
    cyc(); cyc();
  endtask

  task automatic wait_state(input int st, input int limit, input string tag);
    int g = 0;
    while (m_st != st && g < limit) begin cyc(); g++; end
    chk(tag, o_state, st);
  endtask

  initial begin
    int g, blen, tk, dr;
    rst = 1; i_vsync = 0; i_pause = 0; i_restart = 0; i_start = 0; i_apple_ready = 1;
    i_faster = 0; i_slower = 0; i_tick_done = 0; i_failure = 0; i_success = 0;
    model_init();
    #12;
    chk("rst_state", o_state, 0);
    chk("rst_speed", o_speed, SI);
    chk("rst_flags", {o_failure, o_success, o_tick, o_dropped}, 0);
    @(negedge clk); rst = 0;
    chk("first_game_rst", o_game_rst, 1);
    cyc();
    chk("idle_after_clear", o_state, 1);

    // speed saturation
    for (int i = 0; i < 10; i++) begin i_faster = 1; cyc(); end
    chk("speed_max", o_speed, 7);
    i_faster = 1; i_slower = 1; cyc();
    chk("speed_both", o_speed, 7);
    for (int i = 0; i < 9; i++) begin i_slower = 1; cyc(); end
    chk("speed_min", o_speed, 0);
    for (int i = 0; i < 6; i++) begin i_faster = 1; cyc(); end
    chk("speed_6", o_speed, 6);

    // period 2: one tick per two vsync edges
    auto_done = 1; i_start = 1;
    wait_state(2, 20, "enter_run");
    i_start = 0;
    n_tick = 0; n_drop = 0;
    run_edges(8);
    chk("ticks_per2", n_tick, 4);
    chk("drops_per2", n_drop, 0);

    // period 1 with tick_done withheld: timeout exit
    i_faster = 1; auto_done = 0; done_cnt = 0;
    cyc();
    wait_state(3, 600, "reach_tick_p1");
    blen = 0; tk = 0; dr = 0; g = 0;
    cyc();
    while (o_state == 3'd4 && g < 400) begin
      blen++;
      if (o_dropped) dr++;
      if (o_tick) tk++;
      cyc(); g++;
    end
    chk("busy_len", blen, 255);
    chk("busy_ticks", tk, 0);
    chk("busy_drops_seen", dr > 0, 1);
    chk("timeout_exit_state", o_state, 2);
    chk("timeout_drop", o_dropped, 1);

    // pause on the elapsing edge
    i_slower = 1; auto_done = 1;
    cyc();
    g = 0;
    while (!((vcnt % 8) == 0 && m_st == 2 && m_fc == 1 && m_spd == 6) && g < 3000) begin
      cyc(); g++;
    end
    chk("pause_point", o_state, 2);
    i_pause = 1; cyc();
    chk("pause_state", o_state, 5);
    chk("pause_no_tick", o_tick, 0);
    for (int i = 0; i < 20; i++) cyc();
    chk("pause_held", o_state, 5);
    i_pause = 0; cyc();
    chk("unpause", o_state, 2);
    n_tick = 0;
    run_edges(1);
    chk("tick_after_pause", n_tick, 1);

    // simultaneous failure and success in BUSY
    wait_state(4, 200, "reach_busy");
    i_failure = 1; i_success = 1; cyc();
    chk("over_state", o_state, 6);
    chk("over_fail", o_failure, 1);
    chk("over_succ", o_success, 0);
    for (int i = 0; i < 5; i++) cyc();
    chk("over_held", o_state, 6);
    i_restart = 1; cyc();
    chk("restart_clear", o_game_rst, 1);
    chk("restart_flags", {o_failure, o_success}, 0);
    cyc();
    chk("restart_idle", o_state, 1);
    chk("restart_speed", o_speed, 6);

    // apple not ready: lost ticks
    i_apple_ready = 0; i_start = 1;
    wait_state(2, 20, "enter_run2");
    i_start = 0;
    n_tick = 0; n_drop = 0;
    run_edges(4);
    chk("noapple_drops", n_drop, 2);
    chk("noapple_ticks", n_tick, 0);
    chk("noapple_state", o_state, 2);

    // asynchronous reset in BUSY
    i_apple_ready = 1;
    wait_state(4, 200, "reach_busy2");
    #2 rst = 1;
    #1;
    chk("arst_state", o_state, 0);
    chk("arst_outs", {o_dropped, o_tick, o_failure}, 0);
    chk("arst_speed", o_speed, SI);
    @(negedge clk); rst = 0;
    model_init();
    cyc();

    // randomized phase
    rand_mode = 1; auto_done = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 16 == 0) i_pause = ~i_pause;
      i_start = ($urandom % 8 == 0);
      i_apple_ready = ($urandom % 5 != 0);
      i_faster = ($urandom % 10 == 0);
      i_slower = ($urandom % 10 == 0);
      i_tick_done = ($urandom % 6 == 0);
      i_failure = ($urandom % 97 == 0);
      i_success = ($urandom % 113 == 0);
      i_restart = ($urandom % 150 == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter SPEED_W, default 3, width of the speed level.
REQ-002 SHALL have parameter SPEED_INIT, default 2, speed level loaded at reset.
REQ-003 SHALL have parameter DONE_TIMEOUT, default 255, maximum BUSY cycles waiting for i_tick_done.
REQ-004 SHALL have ports exactly as follows; clock and reset: one clock; reset is asynchronous and active-high.
  clk  in  1  system clock, all state on rising edge
  rst  in  1  asynchronous active-high reset
  i_vsync  in  1  VGA vsync level; rising edge = one frame
  i_pause  in  1  level, pause request
  i_restart  in  1  level, game restart request
  i_start  in  1  level, player has given first direction input
  i_apple_ready  in  1  level, apple placement complete
  i_faster  in  1  1-cycle pulse, speed +1
  i_slower  in  1  1-cycle pulse, speed -1
  i_tick_done  in  1  1-cycle pulse, snake finished tick
  i_failure  in  1  1-cycle pulse, snake collision
  i_success  in  1  1-cycle pulse, board full
  o_tick  out  1  1-cycle tick request to snake
  o_game_rst  out  1  1-cycle synchronous clear for game blocks
  o_state  out  3  current state encoding
  o_speed  out  SPEED_W  current speed level
  o_failure  out  1  sticky failure flag
  o_success  out  1  sticky success flag
  o_dropped  out  1  1-cycle pulse, a scheduled tick was lost

Function
REQ-005 SHALL implement states CLEAR=0, IDLE=1, RUN=2, TICK=3, BUSY=4, PAUSED=5, OVER=6; o_state = state register.
REQ-006 SHALL detect vsync edge as i_vsync=1 and registered previous i_vsync=0; previous register resets to 1.
REQ-007 SHALL define period = 2^SPEED_W - o_speed (range 1..2^SPEED_W), computed SPEED_W+1 bits wide.
REQ-008 SHALL count vsync edges in frame_cnt (SPEED_W bits) only in RUN, TICK, BUSY; held in PAUSED; cleared in CLEAR and IDLE.
REQ-009 SHALL declare "period elapsed" on a vsync edge when frame_cnt+1 >= period, then clear frame_cnt; otherwise increment it.
REQ-010 CLEAR: o_game_rst=1 for exactly that cycle, flags cleared, next state IDLE.
REQ-011 IDLE: i_start=1 -> RUN.
REQ-012 RUN: i_pause=1 -> PAUSED (wins over a same-cycle vsync edge, no count); else period elapsed with i_apple_ready=1 -> TICK; period elapsed with i_apple_ready=0 -> o_dropped pulse, stay RUN.
REQ-013 TICK: o_tick=1 for this single cycle (Moore, decoded from state); next BUSY with timeout counter cleared.
REQ-014 BUSY: i_tick_done -> RUN; timeout counter reaches DONE_TIMEOUT -> RUN with o_dropped pulse.
REQ-015 Period elapsed while in TICK or BUSY SHALL pulse o_dropped and not queue a tick.
REQ-016 PAUSED: i_pause=0 -> RUN; frame_cnt resumes from held value.
REQ-017 In RUN/TICK/BUSY, i_failure sets o_failure, i_success sets o_success, next state OVER; both same cycle -> only o_failure set; these take priority over all other transitions except restart.
REQ-018 OVER: held until i_restart; o_failure/o_success stay constant.
REQ-019 i_restart=1 in any state -> CLEAR next cycle; highest priority; held i_restart keeps re-entering CLEAR (o_game_rst asserted every cycle).
REQ-020 o_speed: i_faster +1 saturating at 2^SPEED_W-1, i_slower -1 saturating at 0, both same cycle -> unchanged; active in all states; not affected by restart.
REQ-021 Speed change taking frame_cnt >= new period-1 SHALL cause period elapsed at next vsync edge (by REQ-009 >= compare).
REQ-022 o_dropped SHALL be at most one cycle wide per lost tick; never coincident with o_tick.

Reset
REQ-023 rst=1 SHALL force state CLEAR, frame_cnt=0, timeout=0, o_speed=SPEED_INIT, o_failure=0, o_success=0, o_tick=0, o_dropped=0, vsync-previous=1, immediately and asynchronously.
REQ-024 First cycle after rst deasserts SHALL assert o_game_rst=1 (CLEAR), then IDLE.
REQ-025 rst asserted mid-BUSY SHALL abandon the pending tick with no o_dropped pulse.

Verification
REQ-026 Reset, i_start=1, speed 6 (period 2), apple ready, i_tick_done 3 cycles after o_tick -> o_tick once per 2 vsync edges, o_state 2->3->4->2.
REQ-027 Speed 7 (period 1), i_tick_done withheld -> BUSY exits after 255 cycles with o_dropped=1; vsync edge during BUSY -> additional o_dropped, no o_tick.
REQ-028 i_pause=1 coincident with vsync edge at frame_cnt=period-1 -> PAUSED, no o_tick; release -> o_tick on next vsync edge.
REQ-029 i_failure and i_success same cycle in BUSY -> OVER, o_failure=1, o_success=0; i_restart pulse -> o_game_rst=1 one cycle, flags 0, IDLE, o_speed unchanged.
REQ-030 i_faster x10 from speed 2 -> o_speed=7; i_faster+i_slower same cycle -> 7; i_slower x9 -> 0.
REQ-031 i_apple_ready=0 at period elapsed -> o_dropped=1, o_tick=0, state stays RUN.
